// File: rtl/led_seq_pkg.sv
// Shared constants for the LED ring sequencer: state encoding, shift direction
// and the width helper for the LED position index.
package led_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic int unsigned pos_width(input int unsigned nb_leds);
        return (nb_leds < 2) ? 1 : $clog2(nb_leds);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Shift-rate prescaler: counts 0..limit-1 while enabled, holds while disabled,
// and flags the terminal count combinationally so the caller can register it.
module led_prescaler #(
    parameter int unsigned NB_COUNTER = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_en,
    input  logic [NB_COUNTER-1:0] i_limit,
    output logic                  o_tick
);

    logic [NB_COUNTER-1:0] count;

    // >= rather than == so a limit that shrank mid-period still terminates.
    assign o_tick = i_en && (count >= (i_limit - NB_COUNTER'(1)));

    always_ff @(posedge clk) begin
        if (i_rst || i_clear) begin
            count <= '0;
        end else if (i_en) begin
            count <= o_tick ? '0 : count + NB_COUNTER'(1);
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED ring sequencer: start/pause/stop FSM, single-step, rate-selected shift
// strobe and active-LED position/direction tracking.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned           NB_LEDS    = 12,
    parameter int unsigned           NB_COUNTER = 32,
    parameter logic [NB_COUNTER-1:0] RATE0      = NB_COUNTER'(32'd100_000_000),
    parameter logic [NB_COUNTER-1:0] RATE1      = NB_COUNTER'(32'd50_000_000),
    parameter logic [NB_COUNTER-1:0] RATE2      = NB_COUNTER'(32'd25_000_000),
    parameter logic [NB_COUNTER-1:0] RATE3      = NB_COUNTER'(32'd12_500_000)
) (
    input  logic                              clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic                              i_stop,
    input  logic                              i_pause,
    input  logic                              i_step,
    input  logic [1:0]                        i_sw_speed,
    input  logic                              i_dir,
    output logic                              o_valid,
    output logic                              o_dir,
    output logic [pos_width(NB_LEDS)-1:0]     o_pos,
    output logic                              o_wrap,
    output logic [1:0]                        o_state
);

    localparam int unsigned    PW      = pos_width(NB_LEDS);
    localparam logic [PW-1:0]  POS_MAX = PW'(NB_LEDS - 1);

    logic [1:0]            state_q, state_d;
    logic [1:0]            sel_r;
    logic                  step_q;
    logic                  step_rise;
    logic                  step_fire;
    logic                  pos_clear;
    logic                  presc_en;
    logic                  presc_clear;
    logic                  tick;
    logic                  sel_load;
    logic                  valid_d;
    logic                  wrap_d;
    logic                  dir_d;
    logic                  at_wrap;
    logic [PW-1:0]         pos_d;
    logic [NB_COUNTER-1:0] rate_sel;
    logic [NB_COUNTER-1:0] limit;

    assign step_rise = i_step & ~step_q;

    always_comb begin
        unique case (sel_r)
            2'd0: rate_sel = RATE0;
            2'd1: rate_sel = RATE1;
            2'd2: rate_sel = RATE2;
            2'd3: rate_sel = RATE3;
        endcase
        limit = (rate_sel == '0) ? NB_COUNTER'(1) : rate_sel;
    end

    // Priority in every state: stop > pause > start > step.
    always_comb begin
        state_d   = state_q;
        presc_en  = 1'b0;
        step_fire = 1'b0;
        pos_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_stop) begin
                    pos_clear = 1'b1;
                end else if (i_start) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    step_fire = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_d   = ST_IDLE;
                    pos_clear = 1'b1;
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    presc_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (i_stop) begin
                    state_d   = ST_IDLE;
                    pos_clear = 1'b1;
                end else if (i_start && !i_pause) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    step_fire = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    led_prescaler #(
        .NB_COUNTER (NB_COUNTER)
    ) u_prescaler (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_clear (presc_clear),
        .i_en    (presc_en),
        .i_limit (limit),
        .o_tick  (tick)
    );

    assign presc_clear = (state_d == ST_IDLE);
    assign sel_load    = tick || ((state_q != ST_RUN) && (state_d == ST_RUN));
    assign valid_d     = tick | step_fire;
    // Direction is frozen on the strobe edge so o_dir matches the shift it accompanies.
    assign dir_d       = valid_d ? o_dir : i_dir;
    assign at_wrap     = (o_dir == DIR_UP) ? (o_pos == POS_MAX) : (o_pos == '0);
    assign wrap_d      = valid_d & at_wrap;

    always_comb begin
        pos_d = o_pos;
        if (pos_clear) begin
            pos_d = '0;
        end else if (valid_d) begin
            if (o_dir == DIR_UP) begin
                pos_d = at_wrap ? '0 : o_pos + PW'(1);
            end else begin
                pos_d = at_wrap ? POS_MAX : o_pos - PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            sel_r   <= i_sw_speed;
            step_q  <= 1'b0;
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
            o_dir   <= DIR_UP;
            o_pos   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= i_step;
            if (sel_load) begin
                sel_r <= i_sw_speed;
            end
            o_valid <= valid_d;
            o_wrap  <= wrap_d;
            o_dir   <= dir_d;
            o_pos   <= pos_d;
        end
    end

    assign o_state = state_q;

endmodule
